matrix_mac: RTL and testbench
=============================

MATRIX_MAC -- requirements
Module: matrix_mac

Interface
REQ-001 The block SHALL have parameter M, default 4: rows of op_a and prod.
REQ-002 The block SHALL have parameter K, default 4: columns of op_a and rows of op_b (inner dimension).
REQ-003 The block SHALL have parameter N, default 4: columns of op_b, op_c and prod.
REQ-004 The block SHALL have parameter W, default 16: signed two's-complement width of each op_a/op_b element.
REQ-005 The block SHALL have parameter OW, default 2*W+clog2(K)+1: signed width of each op_c/prod element.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-009 The block SHALL have port acc_mode, input, 1 bit: 1 computes A*B+C; 0 computes A*B.
REQ-010 The block SHALL have port op_a, input, M*K*W bits: element (r,c) at bits [(r*K+c)*W +: W].
REQ-011 The block SHALL have port op_b, input, K*N*W bits: element (r,c) at bits [(r*N+c)*W +: W].
REQ-012 The block SHALL have port op_c, input, M*N*OW bits: element (r,c) at bits [(r*N+c)*OW +: OW].
REQ-013 The block SHALL have port prod, output, M*N*OW bits: result, packed as op_c.
REQ-014 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when prod is complete.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky per operation; high if any element saturated.

Function
REQ-017 The FSM SHALL have states IDLE, MAC and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch op_a, op_b, op_c and acc_mode into internal registers, clear i/j/k, clear overflow, and go to MAC; busy SHALL rise in the next cycle.
REQ-019 Inputs SHALL NOT be sampled after the start edge; input changes during MAC SHALL NOT affect the result.
REQ-020 start SHALL be ignored in MAC and DONE.
REQ-021 MAC SHALL perform exactly one W x W signed multiply-accumulate per cycle into a 2*W+clog2(K)+OW-bit signed accumulator, with k innermost, then j, then i.
REQ-022 At k=0, the accumulator seed SHALL be sign-extended C(i,j) when acc_mode=1 and zero otherwise.
REQ-023 At k=K-1, acc+A(i,k)*B(k,j) SHALL be written to prod(i,j) in the same cycle, saturated to [-2^(OW-1), 2^(OW-1)-1]; any saturation SHALL set overflow.
REQ-024 After the write for (M-1,N-1), the FSM SHALL go to DONE; MAC SHALL last exactly M*N*K cycles.
REQ-025 In DONE, done=1 and busy=0 for one cycle, then the FSM SHALL return to IDLE.
REQ-026 If start is sampled at edge e0, done SHALL be high in the cycle following edge e0+M*N*K.
REQ-027 prod and overflow SHALL hold their values after DONE until the next accepted start.
REQ-028 prod elements SHALL update only when written (REQ-023); unwritten elements SHALL keep their previous values.
REQ-029 start=1 during the DONE cycle SHALL be ignored; start held high into IDLE SHALL begin a new operation on the next edge.
REQ-030 Counters SHALL be sized clog2 of their bound plus 1 and SHALL never wrap mid-operation.
REQ-031 The design SHALL be legal for any M, K, N >= 1 (including 1x1x1) and any W >= 2.

Reset
REQ-032 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, go to IDLE and drive prod=0, busy=0, done=0 and overflow=0, with counters cleared.
REQ-033 Reset asserted during MAC SHALL abort the operation, leaving no partial result visible.
REQ-034 After rst_n rises, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-035 Identity check, defaults, acc_mode=0: A=I, B(r,c)=r*4+c, pulse start -> done exactly 64 cycles later; prod=B; overflow=0.
REQ-036 Accumulate check: A=B=all 1, C=all -5, acc_mode=1 -> every prod element = -1.
REQ-037 Saturation check, W=8, OW=16, K=4: A=B=all -128 -> each element = 65536, clamped to 32767; overflow=1; the next clean operation clears overflow.
REQ-038 Stress check: start held high and op_a changed during MAC -> result matches latched operands; done pulses once per operation; next operation begins the cycle after DONE.
REQ-039 Reset check: rst_n=0 at MAC cycle 10 -> prod=0 and busy=0 asynchronously; a new start runs to completion correctly.
REQ-040 Non-square check: M=2, K=3, N=1 with random signed operands -> prod matches a reference model; done 6 cycles after start.

Source files
------------

// File: rtl/matrix_mac.sv
// matrix_mac: sequential signed matrix multiply / multiply-accumulate.
// Computes prod = A*B (acc_mode=0) or A*B+C (acc_mode=1), one W x W MAC
// per clock, walking k innermost, then j, then i. Each result element is
// saturated to OW bits; any clamp sets the sticky overflow flag.
//
// Handshake: start is a level request that is only sampled in IDLE; the
// cycle after it is sampled, busy is high for exactly M*N*K cycles, then
// done is high (busy low) for exactly one cycle while prod/overflow are
// final. prod/overflow then hold until the next accepted start.
module matrix_mac #(
   parameter int M  = 4,
   parameter int K  = 4,
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int OW = 2*W + $clog2(K) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              acc_mode,
   input  logic [M*K*W-1:0]  op_a,
   input  logic [K*N*W-1:0]  op_b,
   input  logic [M*N*OW-1:0] op_c,
   output logic [M*N*OW-1:0] prod,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   // Accumulator wide enough to hold C plus K full-scale products.
   localparam int AW = 2*W + $clog2(K) + OW;
   localparam int IW = $clog2(M) + 1;
   localparam int JW = $clog2(N) + 1;
   localparam int KW = $clog2(K) + 1;

   localparam logic [IW-1:0] I_LAST = IW'(M - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);

   // Saturation bounds of an OW-bit signed element, sign-extended to AW.
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [M*K*W-1:0]    a_q, a_d;
   logic [K*N*W-1:0]    b_q, b_d;
   logic [M*N*OW-1:0]   c_q, c_d;
   logic                acc_mode_q, acc_mode_d;
   logic [IW-1:0]       i_q, i_d;
   logic [JW-1:0]       j_q, j_d;
   logic [KW-1:0]       k_q, k_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [M*N*OW-1:0]   prod_q, prod_d;
   logic                ovf_q, ovf_d;

   // Datapath intermediates for the current (i,j,k) step.
   logic signed [W-1:0]    a_el;
   logic signed [W-1:0]    b_el;
   logic [OW-1:0]          c_el;
   logic signed [2*W-1:0]  term;
   logic signed [AW-1:0]   term_ext;
   logic signed [AW-1:0]   c_ext;
   logic signed [AW-1:0]   seed;
   logic signed [AW-1:0]   sum;
   logic [OW-1:0]          sat_val;
   logic                   sat_hit;

   // One MAC step: select operands, seed on k=0, add, and saturate.
   always_comb begin
      a_el     = a_q[(int'(i_q) * K + int'(k_q)) * W +: W];
      b_el     = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];
      c_el     = c_q[(int'(i_q) * N + int'(j_q)) * OW +: OW];
      term     = a_el * b_el;
      term_ext = {{(AW-2*W){term[2*W-1]}}, term};
      c_ext    = {{(AW-OW){c_el[OW-1]}}, c_el};
      if (k_q == '0) begin
         seed = acc_mode_q ? c_ext : '0;
      end else begin
         seed = acc_q;
      end
      sum = seed + term_ext;
      if (sum > SAT_MAX) begin
         sat_val = SAT_MAX[OW-1:0];
         sat_hit = 1'b1;
      end else if (sum < SAT_MIN) begin
         sat_val = SAT_MIN[OW-1:0];
         sat_hit = 1'b1;
      end else begin
         sat_val = sum[OW-1:0];
         sat_hit = 1'b0;
      end
   end

   // Next-state logic: operand latch, loop counters, result writes.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      acc_mode_d = acc_mode_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      acc_d      = acc_q;
      prod_d     = prod_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d        = op_a;
               b_d        = op_b;
               c_d        = op_c;
               acc_mode_d = acc_mode;
               i_d        = '0;
               j_d        = '0;
               k_d        = '0;
               acc_d      = '0;
               ovf_d      = 1'b0;
               state_d    = S_MAC;
            end
         end
         S_MAC: begin
            if (k_q == K_LAST) begin
               // Last product of the dot product: commit element (i,j).
               prod_d[(int'(i_q) * N + int'(j_q)) * OW +: OW] = sat_val;
               if (sat_hit) begin
                  ovf_d = 1'b1;
               end
               k_d = '0;
               if (j_q == J_LAST) begin
                  j_d = '0;
                  if (i_q == I_LAST) begin
                     i_d     = '0;
                     state_d = S_DONE;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               acc_d = sum;
               k_d   = k_q + 1'b1;
            end
         end
         S_DONE: begin
            // start is deliberately ignored here; IDLE samples it next.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         acc_mode_q <= 1'b0;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         prod_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         acc_mode_q <= acc_mode_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         prod_q     <= prod_d;
         ovf_q      <= ovf_d;
      end
   end

   assign prod     = prod_q;
   assign overflow = ovf_q;
   assign busy     = (state_q == S_MAC);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_mac.sv
// tb_matrix_mac: checks three matrix_mac configurations (4x4x4 W16,
// 4x4x4 W8/OW16, 2x3x1 W16) against an arithmetic reference model and a
// table of hand-computed saturation / accumulate vectors.
module tb_matrix_mac;

   localparam int OW0 = 35;
   localparam int OW1 = 16;
   localparam int OW2 = 35;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT 0: defaults ----------------
   logic               s0, acc0, busy0, done0, ovf0;
   logic [16*16-1:0]   a0, b0;
   logic [16*OW0-1:0]  c0, p0;
   matrix_mac u_d0 (
      .clk(clk), .rst_n(rst_n), .start(s0), .acc_mode(acc0),
      .op_a(a0), .op_b(b0), .op_c(c0), .prod(p0),
      .busy(busy0), .done(done0), .overflow(ovf0)
   );

   // ---------------- DUT 1: W=8, OW=16 ----------------
   logic               s1, acc1, busy1, done1, ovf1;
   logic [16*8-1:0]    a1, b1;
   logic [16*OW1-1:0]  c1, p1;
   matrix_mac #(.M(4), .K(4), .N(4), .W(8), .OW(OW1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .acc_mode(acc1),
      .op_a(a1), .op_b(b1), .op_c(c1), .prod(p1),
      .busy(busy1), .done(done1), .overflow(ovf1)
   );

   // ---------------- DUT 2: 2x3x1 ----------------
   logic               s2, acc2, busy2, done2, ovf2;
   logic [6*16-1:0]    a2;
   logic [3*16-1:0]    b2;
   logic [2*OW2-1:0]   c2, p2;
   matrix_mac #(.M(2), .K(3), .N(1), .W(16), .OW(OW2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .acc_mode(acc2),
      .op_a(a2), .op_b(b2), .op_c(c2), .prod(p2),
      .busy(busy2), .done(done2), .overflow(ovf2)
   );

   // ---------------- reference model ----------------
   longint ma [4][4];
   longint mb [4][4];
   longint mc [4][4];
   longint mp [4][4];
   longint oldp [4][4];
   bit     m_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q [$];

   typedef struct {
      longint av;
      longint bv;
      longint cv;
      bit     acc;
      longint exp_el;
      bit     exp_ovf;
   } vec_t;
   vec_t tbl [10];

   // Plain matrix arithmetic with clamping to an ow-bit signed range.
   task automatic run_model(input int m, input int k, input int n, input int ow, input bit acc);
      longint s, hi, lo;
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
      m_ovf = 1'b0;
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < n; j++) begin
            s = acc ? mc[i][j] : 0;
            for (int kk = 0; kk < k; kk++) s += ma[i][kk] * mb[kk][j];
            if (s > hi) begin s = hi; m_ovf = 1'b1; end
            if (s < lo) begin s = lo; m_ovf = 1'b1; end
            mp[i][j] = s;
         end
      end
   endtask

   function automatic longint rand_s(input int w);
      return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
   endfunction

   task automatic rand_mats(input int m, input int k, input int n, input int w, input int cw);
      for (int i = 0; i < m; i++) for (int kk = 0; kk < k; kk++) ma[i][kk] = rand_s(w);
      for (int kk = 0; kk < k; kk++) for (int j = 0; j < n; j++) mb[kk][j] = rand_s(w);
      for (int i = 0; i < m; i++) for (int j = 0; j < n; j++) mc[i][j] = rand_s(cw);
   endtask

   // ---------------- driver tasks ----------------
   task automatic pack(input int sel);
      longint t;
      case (sel)
         0: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
               t = ma[r][c]; a0[(r*4+c)*16 +: 16]   = t[15:0];
               t = mb[r][c]; b0[(r*4+c)*16 +: 16]   = t[15:0];
               t = mc[r][c]; c0[(r*4+c)*OW0 +: OW0] = t[OW0-1:0];
            end
         1: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
               t = ma[r][c]; a1[(r*4+c)*8 +: 8]     = t[7:0];
               t = mb[r][c]; b1[(r*4+c)*8 +: 8]     = t[7:0];
               t = mc[r][c]; c1[(r*4+c)*OW1 +: OW1] = t[OW1-1:0];
            end
         default: begin
            for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) begin
               t = ma[r][c]; a2[(r*3+c)*16 +: 16] = t[15:0];
            end
            for (int r = 0; r < 3; r++) begin
               t = mb[r][0]; b2[r*16 +: 16] = t[15:0];
            end
            for (int r = 0; r < 2; r++) begin
               t = mc[r][0]; c2[r*OW2 +: OW2] = t[OW2-1:0];
            end
         end
      endcase
   endtask

   function automatic logic signed [63:0] get_elem(input int sel, input int r, input int c);
      logic signed [63:0] v;
      case (sel)
         0:       v = 64'($signed(p0[(r*4+c)*OW0 +: OW0]));
         1:       v = 64'($signed(p1[(r*4+c)*OW1 +: OW1]));
         default: v = 64'($signed(p2[(r+c)*OW2 +: OW2]));
      endcase
      return v;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
   endfunction
   function automatic logic get_ovf(input int sel);
      return (sel == 0) ? ovf0 : (sel == 1) ? ovf1 : ovf2;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_prod(input int sel, input int m, input int n, input string name);
      logic [63:0] e;
      for (int r = 0; r < m; r++) for (int c = 0; c < n; c++) exp_q.push_back(mp[r][c]);
      for (int r = 0; r < m; r++) begin
         for (int c = 0; c < n; c++) begin
            e = exp_q.pop_front();
            check($sformatf("%s prod(%0d,%0d)", name, r, c), get_elem(sel, r, c), e);
         end
      end
   endtask

   // Pulse start for one edge; afterwards we sit #1 past that edge (e0).
   task automatic start_op(input int sel, input bit acc, input string name);
      @(negedge clk);
      case (sel)
         0:       begin acc0 = acc; s0 = 1'b1; end
         1:       begin acc1 = acc; s1 = 1'b1; end
         default: begin acc2 = acc; s2 = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
      check_bit({name, " busy after start"}, get_busy(sel), 1'b1);
   endtask

   // Count edges after e0 until done; then confirm done lasts one cycle.
   task automatic wait_done(input int sel, input int exp_cycles, input string name);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 2000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (get_done(sel) === 1'b1) seen = 1'b1;
      end
      check({name, " done latency"}, seen ? 64'(cnt) : -64'sd1, 64'(exp_cycles));
      check_bit({name, " busy low at done"}, get_busy(sel), 1'b0);
      @(posedge clk);
      #1;
      check_bit({name, " done one cycle"}, get_done(sel), 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      tbl[0] = '{-128, -128,    0, 1'b0,  32767, 1'b1};
      tbl[1] = '{  10,   -3,  100, 1'b1,    -20, 1'b0};
      tbl[2] = '{   1,    1,   -5, 1'b1,     -1, 1'b0};
      tbl[3] = '{ 127, -128,    0, 1'b0, -32768, 1'b1};
      tbl[4] = '{  64,   64,    0, 1'b0,  16384, 1'b0};
      tbl[5] = '{  90,   90,  367, 1'b1,  32767, 1'b0};
      tbl[6] = '{  90,   90,  368, 1'b1,  32767, 1'b1};
      tbl[7] = '{-128,   64,    0, 1'b0, -32768, 1'b0};
      tbl[8] = '{-128,   64,   -1, 1'b1, -32768, 1'b1};
      tbl[9] = '{   2,    3, 1000, 1'b0,     24, 1'b0};

      s0 = 0; s1 = 0; s2 = 0; acc0 = 0; acc1 = 0; acc2 = 0;
      a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0; a2 = '0; b2 = '0; c2 = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mp[r][c] = 0;
      check_prod(0, 4, 4, "reset d0");
      check_bit("reset busy0", busy0, 1'b0);
      check_bit("reset done0", done0, 1'b0);
      check_bit("reset ovf0", ovf0, 1'b0);
      check_bit("reset busy2", busy2, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Identity: A=I, B(r,c)=r*4+c, so prod must equal B.
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
         ma[r][c] = (r == c) ? 1 : 0;
         mb[r][c] = r * 4 + c;
         mc[r][c] = 0;
      end
      pack(0);
      run_model(4, 4, 4, OW0, 1'b0);
      start_op(0, 1'b0, "ident");
      wait_done(0, 64, "ident");
      check_prod(0, 4, 4, "ident");
      check_bit("ident ovf", ovf0, 1'b0);

      // Accumulate: all ones with C=-5 gives -1 everywhere.
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
         ma[r][c] = 1; mb[r][c] = 1; mc[r][c] = -5;
      end
      pack(0);
      run_model(4, 4, 4, OW0, 1'b1);
      start_op(0, 1'b1, "accum");
      wait_done(0, 64, "accum");
      check_prod(0, 4, 4, "accum");
      check_bit("accum ovf", ovf0, 1'b0);

      // Saturation / boundary table on the narrow configuration.
      for (int t = 0; t < 10; t++) begin
         for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
            ma[r][c] = tbl[t].av; mb[r][c] = tbl[t].bv; mc[r][c] = tbl[t].cv;
            mp[r][c] = tbl[t].exp_el;
         end
         pack(1);
         start_op(1, tbl[t].acc, $sformatf("tbl%0d", t));
         wait_done(1, 64, $sformatf("tbl%0d", t));
         check_prod(1, 4, 4, $sformatf("tbl%0d", t));
         check_bit($sformatf("tbl%0d ovf", t), ovf1, tbl[t].exp_ovf);
      end

      // Random operands on the narrow configuration (saturation likely).
      for (int t = 0; t < 4; t++) begin
         bit acc;
         acc = 1'($urandom_range(0, 1));
         rand_mats(4, 4, 4, 8, OW1);
         pack(1);
         run_model(4, 4, 4, OW1, acc);
         start_op(1, acc, $sformatf("rnd1_%0d", t));
         wait_done(1, 64, $sformatf("rnd1_%0d", t));
         check_prod(1, 4, 4, $sformatf("rnd1_%0d", t));
         check_bit($sformatf("rnd1_%0d ovf", t), ovf1, m_ovf);
      end

      // Random operands on the default configuration.
      for (int t = 0; t < 3; t++) begin
         bit acc;
         acc = 1'($urandom_range(0, 1));
         rand_mats(4, 4, 4, 16, 30);
         pack(0);
         run_model(4, 4, 4, OW0, acc);
         start_op(0, acc, $sformatf("rnd0_%0d", t));
         wait_done(0, 64, $sformatf("rnd0_%0d", t));
         check_prod(0, 4, 4, $sformatf("rnd0_%0d", t));
         check_bit($sformatf("rnd0_%0d ovf", t), ovf0, m_ovf);
      end

      // Stress: start held high, op_a/op_c/acc_mode scrambled during MAC.
      rand_mats(4, 4, 4, 16, 30);
      pack(0);
      run_model(4, 4, 4, OW0, 1'b1);
      @(negedge clk);
      acc0 = 1'b1;
      s0   = 1'b1;
      @(posedge clk);
      #1;
      check_bit("stress busy after start", busy0, 1'b1);
      for (int w = 0; w < 8; w++) a0[w*32 +: 32] = $urandom;
      for (int w = 0; w < 16; w++) c0[w*OW0 +: 32] = $urandom;
      acc0 = 1'b0;
      wait_done(0, 64, "stress1");
      check_prod(0, 4, 4, "stress1");
      // One cycle into IDLE with start still high: new operands, then accept.
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) ma[r][c] = rand_s(16);
      pack(0);
      acc0 = 1'b1;
      run_model(4, 4, 4, OW0, 1'b1);
      @(posedge clk);
      #1;
      check_bit("stress restart busy", busy0, 1'b1);
      s0 = 1'b0;
      wait_done(0, 64, "stress2");
      check_prod(0, 4, 4, "stress2");
      check_bit("stress2 ovf", ovf0, m_ovf);

      // Reset during MAC cycle 10: partial state must vanish asynchronously.
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) oldp[r][c] = mp[r][c];
      rand_mats(4, 4, 4, 16, 30);
      pack(0);
      run_model(4, 4, 4, OW0, 1'b1);
      start_op(0, 1'b1, "rstmid");
      repeat (10) @(posedge clk);
      #2;
      check("rstmid written (0,0)", get_elem(0, 0, 0), mp[0][0]);
      check("rstmid unwritten (3,3)", get_elem(0, 3, 3), oldp[3][3]);
      check_bit("rstmid busy before reset", busy0, 1'b1);
      rst_n = 1'b0;
      #1;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mp[r][c] = 0;
      check_prod(0, 4, 4, "rstmid async");
      check_bit("rstmid async busy", busy0, 1'b0);
      check_bit("rstmid async done", done0, 1'b0);
      check_bit("rstmid async ovf", ovf0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rand_mats(4, 4, 4, 16, 30);
      pack(0);
      run_model(4, 4, 4, OW0, 1'b0);
      start_op(0, 1'b0, "after_rst");
      wait_done(0, 64, "after_rst");
      check_prod(0, 4, 4, "after_rst");
      check_bit("after_rst ovf", ovf0, m_ovf);

      // Non-square 2x3x1 with random signed operands.
      for (int t = 0; t < 5; t++) begin
         bit acc;
         acc = 1'($urandom_range(0, 1));
         rand_mats(2, 3, 1, 16, 30);
         pack(2);
         run_model(2, 3, 1, OW2, acc);
         start_op(2, acc, $sformatf("ns_%0d", t));
         wait_done(2, 6, $sformatf("ns_%0d", t));
         check_prod(2, 2, 1, $sformatf("ns_%0d", t));
         check_bit($sformatf("ns_%0d ovf", t), ovf2, m_ovf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run cannot hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
